// File: rtl/mem_writein_demux.sv
// Purpose: demultiplex a merged stub stream into per-memory BX pages and publish per-event item counts.
// Latency: 1 clk from an accepted input word to its wr_en/wr_addr/wr_dat.
// Backpressure: none; one word per cycle is accepted, and words that cannot be written are dropped and flagged.
module mem_writein_demux #(
    parameter int N_MEM  = 12,
    parameter int DAT_W  = 45,
    parameter int ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_event,
    input  logic [2:0]                BX,
    input  logic [53:0]               mem_dat_stream,
    input  logic                      valid,
    output logic [N_MEM-1:0]          wr_en,
    output logic [ADDR_W:0]           wr_addr,
    output logic [DAT_W-1:0]          wr_dat,
    output logic [N_MEM*ADDR_W-1:0]   number_out,
    output logic [N_MEM-1:0]          overflow,
    output logic                      bad_id,
    output logic                      bx_err,
    output logic                      active
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  page;
    logic [2:0]            cur_bx;
    logic [ADDR_W-1:0]     cnt [N_MEM];

    logic [3:0]            word_id;
    logic [2:0]            word_bx;
    logic [DAT_W-1:0]      word_dat;
    logic [ADDR_W-1:0]     sel_cnt;
    logic                  id_ok;
    logic                  bx_ok;
    logic                  page_full;
    logic                  take;

    assign word_id  = mem_dat_stream[53:50];
    assign word_bx  = mem_dat_stream[49:47];
    assign word_dat = mem_dat_stream[DAT_W-1:0];
    assign active   = (state == RUN);

    // Only the first new_event leaves IDLE; later ones are event rollovers within RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state.
    always_comb begin
        state_nxt = state;
        if (new_event) state_nxt = RUN;
    end

    // Decode the incoming word; out-of-range ids select no counter, so no X reaches the datapath.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < N_MEM; i++) begin
            if (int'(word_id) == i) sel_cnt = cnt[i];
        end
        id_ok     = int'(word_id) < N_MEM;
        bx_ok     = (word_bx == cur_bx);
        page_full = (sel_cnt == {ADDR_W{1'b1}});
        take      = (state == RUN) && valid && !new_event;
    end

    // Event rollover, the drop checks in priority order (bad id, then BX, then full page), and the page write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_dat     <= '0;
            number_out <= '0;
            overflow   <= '0;
            bad_id     <= 1'b0;
            bx_err     <= 1'b0;
            page       <= 1'b0;
            cur_bx     <= '0;
            for (int i = 0; i < N_MEM; i++) cnt[i] <= '0;
        end else begin
            wr_en <= '0;
            if (new_event) begin
                for (int i = 0; i < N_MEM; i++) begin
                    number_out[i*ADDR_W +: ADDR_W] <= cnt[i];
                    cnt[i]                         <= '0;
                end
                page     <= ~page;
                cur_bx   <= BX;
                overflow <= '0;
                bad_id   <= 1'b0;
                bx_err   <= 1'b0;
            end else if (take) begin
                if (!id_ok) begin
                    bad_id <= 1'b1;
                end else if (!bx_ok) begin
                    bx_err <= 1'b1;
                end else if (page_full) begin
                    for (int i = 0; i < N_MEM; i++) begin
                        if (int'(word_id) == i) overflow[i] <= 1'b1;
                    end
                end else begin
                    for (int i = 0; i < N_MEM; i++) begin
                        if (int'(word_id) == i) begin
                            wr_en[i] <= 1'b1;
                            cnt[i]   <= sel_cnt + 1'b1;
                        end
                    end
                    wr_addr <= {page, sel_cnt};
                    wr_dat  <= word_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_writein_demux.sv
// Testbench for mem_writein_demux: directed scenarios plus randomized traffic against a behavioural model.
// Latency: the model predicts outputs one clock after the inputs are applied.
// Backpressure: not applicable; a word may be driven every cycle.
module tb_mem_writein_demux;

    localparam int N_MEM  = 12;
    localparam int DAT_W  = 45;
    localparam int ADDR_W = 6;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    new_event;
    logic [2:0]              BX;
    logic [53:0]             mem_dat_stream;
    logic                    valid;
    logic [N_MEM-1:0]        wr_en;
    logic [ADDR_W:0]         wr_addr;
    logic [DAT_W-1:0]        wr_dat;
    logic [N_MEM*ADDR_W-1:0] number_out;
    logic [N_MEM-1:0]        overflow;
    logic                    bad_id;
    logic                    bx_err;
    logic                    active;

    mem_writein_demux #(.N_MEM(N_MEM), .DAT_W(DAT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .new_event(new_event), .BX(BX),
        .mem_dat_stream(mem_dat_stream), .valid(valid), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_dat(wr_dat), .number_out(number_out),
        .overflow(overflow), .bad_id(bad_id), .bx_err(bx_err), .active(active)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: one item counter per memory, plus the published counts.
    bit               m_run;
    int               m_page;
    int               m_bx;
    int               m_cnt [N_MEM];
    int               m_num [N_MEM];
    logic [N_MEM-1:0] m_ovf;
    bit               m_bad;
    bit               m_bxe;
    logic [N_MEM-1:0] e_wren;
    int               e_addr;
    logic [DAT_W-1:0] e_dat;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_page = 0; m_bx = 0; m_ovf = '0; m_bad = 0; m_bxe = 0;
        e_wren = '0; e_addr = 0; e_dat = '0;
        for (int i = 0; i < N_MEM; i++) begin m_cnt[i] = 0; m_num[i] = 0; end
    endtask

    task automatic model_step(input bit ne, input int bx, input bit v, input int id,
                              input int wbx, input logic [DAT_W-1:0] pay);
        e_wren = '0;
        if (ne) begin
            for (int i = 0; i < N_MEM; i++) begin m_num[i] = m_cnt[i]; m_cnt[i] = 0; end
            m_page = 1 - m_page;
            m_bx   = bx;
            m_ovf  = '0; m_bad = 0; m_bxe = 0;
            m_run  = 1;
        end else if (m_run && v) begin
            if (id >= N_MEM)               m_bad = 1;
            else if (wbx != m_bx)          m_bxe = 1;
            else if (m_cnt[id] == 63)      m_ovf[id] = 1'b1;
            else begin
                e_wren[id] = 1'b1;
                e_addr     = m_page * 64 + m_cnt[id];
                e_dat      = pay;
                m_cnt[id]  = m_cnt[id] + 1;
            end
        end
    endtask

    task automatic check_all();
        logic [N_MEM*ADDR_W-1:0] exp_num;
        for (int i = 0; i < N_MEM; i++) exp_num[i*ADDR_W +: ADDR_W] = ADDR_W'(m_num[i]);
        chk("wr_en", wr_en, e_wren);
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_dat", wr_dat, e_dat);
        chk("number_out", number_out, exp_num);
        chk("overflow", overflow, m_ovf);
        chk("bad_id", bad_id, m_bad);
        chk("bx_err", bx_err, m_bxe);
        chk("active", active, m_run);
    endtask

    // Apply one cycle of inputs at the falling edge, then check just after the rising edge.
    task automatic drive(input bit ne, input int bx, input bit v, input int id,
                         input int wbx, input logic [DAT_W-1:0] pay);
        @(negedge clk);
        new_event      = ne;
        BX             = 3'(bx);
        valid          = v;
        mem_dat_stream = {4'(id), 3'(wbx), 2'b00, pay};
        @(posedge clk);
        #1;
        model_step(ne, bx, v, id, wbx, pay);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        new_event = 1'b0;
        valid     = 1'b0;
        reset     = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [DAT_W-1:0] rnd_pay();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DAT_W-1:0];
    endfunction

    initial begin
        int cbx;
        reset = 1'b1; new_event = 1'b0; BX = '0; valid = 1'b0; mem_dat_stream = '0;
        model_reset();
        #2;
        check_all();
        do_reset();

        // Scenario 1: first event BX=3, three words to memory 2 and one to memory 5.
        drive(1, 3, 0, 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 2, 3, rnd_pay());
            chk("t1_addr2", wr_addr, 64 + k);
        end
        drive(0, 0, 1, 5, 3, rnd_pay());
        chk("t1_en5", wr_en, 12'h020);
        chk("t1_addr5", wr_addr, 64);
        drive(1, 5, 0, 0, 0, '0);
        chk("t1_num2", number_out[2*ADDR_W +: ADDR_W], 3);
        chk("t1_num5", number_out[5*ADDR_W +: ADDR_W], 1);
        chk("t1_num0", number_out[0 +: ADDR_W], 0);

        // Scenario 2: overfill memory 0 in page 0.
        for (int k = 0; k < 64; k++) begin
            drive(0, 0, 1, 0, 5, rnd_pay());
            if (k < 63) chk("t2_addr", wr_addr, k);
        end
        chk("t2_en_full", wr_en, 0);
        chk("t2_ovf", overflow[0], 1);
        drive(1, 6, 0, 0, 0, '0);
        chk("t2_num0", number_out[0 +: ADDR_W], 63);

        // Scenario 3: bad id has priority over a BX mismatch.
        drive(0, 0, 1, 12, 6, rnd_pay());
        chk("t3_bad", bad_id, 1);
        drive(0, 0, 1, 13, 1, rnd_pay());
        chk("t3_bxerr", bx_err, 0);

        // Scenario 4: BX mismatch flags bx_err until the next event.
        drive(1, 3, 0, 0, 0, '0);
        drive(0, 0, 1, 1, 4, rnd_pay());
        chk("t4_bxerr", bx_err, 1);
        drive(1, 3, 0, 0, 0, '0);
        chk("t4_clr", bx_err, 0);

        // Scenario 5: a word coincident with new_event is dropped silently.
        drive(1, 2, 1, 3, 2, rnd_pay());
        chk("t5_en", wr_en, 0);
        drive(0, 0, 1, 3, 2, rnd_pay());
        chk("t5_addr", wr_addr[ADDR_W-1:0], 0);

        // Scenario 6: reset mid-event, then words are ignored until an event opens.
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 4, 2, rnd_pay());
        do_reset();
        chk("t6_num4", number_out, 0);
        drive(0, 0, 1, 4, 0, rnd_pay());
        chk("t6_idle_en", wr_en, 0);

        // Randomized traffic, mostly into a few memories so pages fill up.
        cbx = 0;
        for (int n = 0; n < 4000; n++) begin
            int r, id, wbx, nbx;
            bit ne;
            r   = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset();
                cbx = 0;
                continue;
            end
            ne  = (r < 14);
            nbx = $urandom_range(0, 7);
            id  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            wbx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : cbx;
            drive(ne, nbx, $urandom_range(0, 3) != 0, id, wbx, rnd_pay());
            if (ne) cbx = nbx;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
